e_stage_unit: RTL

// - Execute stage of the 5-stage MIPS pipeline. Consumes the D/E pipeline registers (IRE, PC4E, RSE, RTE, EXTE).
// - Applies E-stage forwarding, then runs the ALU and a multi-cycle mult/div unit holding HI/LO.
// - Registers its results into the E/M pipeline registers (IRM, PC4M, AOM, RTM).
// - Drives Start/Busy to the hazard unit, which stalls D on mult/div conflicts.

---
 rtl/e_stage_unit_pkg.sv | 100 ++++++++++
 rtl/e_stage_unit_md_unit_E.sv | 75 +++++++
 rtl/e_stage_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/e_stage_unit_pkg.sv
// Opcode/funct constants, forwarding source codes and decode helpers shared by
// the execute stage and its mult/div unit.
package e_stage_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_AO_M  = 2'd1;
  localparam logic [1:0] FWD_WD_W  = 2'd2;
  localparam logic [1:0] FWD_PC8_M = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    ALU_ZERO, ALU_ADD, ALU_ADD_EXT, ALU_SUB, ALU_AND, ALU_OR, ALU_OR_EXT,
    ALU_EXT, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_HI, ALU_LO
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  } md_op_e;

  function automatic alu_op_e decode_alu(input logic [31:0] ir);
    alu_op_e op;
    op = ALU_ZERO;
    if (ir[31:26] == OP_SPECIAL) begin
      case (ir[5:0])
        FN_ADDU: op = ALU_ADD;
        FN_SUBU: op = ALU_SUB;
        FN_AND:  op = ALU_AND;
        FN_OR:   op = ALU_OR;
        FN_SLT:  op = ALU_SLT;
        FN_SLTU: op = ALU_SLTU;
        FN_SLL:  op = ALU_SLL;
        FN_MFHI: op = ALU_HI;
        FN_MFLO: op = ALU_LO;
        default: op = ALU_ZERO;
      endcase
    end else begin
      case (ir[31:26])
        OP_ADDIU, OP_LW, OP_SW: op = ALU_ADD_EXT;
        OP_ORI:  op = ALU_OR_EXT;
        OP_LUI:  op = ALU_EXT;
        default: op = ALU_ZERO;
      endcase
    end
    return op;
  endfunction

  function automatic md_op_e decode_md(input logic [31:0] ir);
    md_op_e op;
    op = MD_NONE;
    if (ir[31:26] == OP_SPECIAL) begin
      case (ir[5:0])
        FN_MULT:  op = MD_MULT;
        FN_MULTU: op = MD_MULTU;
        FN_DIV:   op = MD_DIV;
        FN_DIVU:  op = MD_DIVU;
        FN_MTHI:  op = MD_MTHI;
        FN_MTLO:  op = MD_MTLO;
        default:  op = MD_NONE;
      endcase
    end
    return op;
  endfunction

  function automatic logic [31:0] fwd_sel(input logic [1:0] src, input logic [31:0] rf,
                                          input logic [31:0] ao_m, input logic [31:0] wd_w,
                                          input logic [31:0] pc8_m);
    case (src)
      FWD_AO_M:  return ao_m;
      FWD_WD_W:  return wd_w;
      FWD_PC8_M: return pc8_m;
      default:   return rf;
    endcase
  endfunction

endpackage

// File: rtl/e_stage_unit_md_unit_E.sv
// Multi-cycle mult/div unit: HI/LO, busy counter and the result latch that
// commits to HI/LO on the last busy cycle.
module md_unit_E
  import e_stage_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  md_op_e      md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [31:0]   res_hi, res_lo;
  logic          res_ok;
  logic          is_mul, is_div, sgn;
  logic [63:0]   prod;
  logic [31:0]   b_nz, quo, rem;

  assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign sgn    = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign Start  = (is_mul || is_div) && !Busy;

  // Sign-extend for signed ops; the low 64 bits of the product are then correct either way.
  assign prod = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
  // b_nz keeps the divider free of X on divide-by-zero; that result is never committed.
  assign b_nz = (b == 32'd0) ? 32'd1 : b;
  assign quo  = sgn ? 32'($signed(a) / $signed(b_nz)) : a / b_nz;
  assign rem  = sgn ? 32'($signed(a) % $signed(b_nz)) : a % b_nz;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_ok <= 1'b0;
    end else if (Start) begin
      Busy   <= 1'b1;
      cnt    <= is_mul ? MULT_LAST : DIV_LAST;
      res_hi <= is_mul ? prod[63:32] : rem;
      res_lo <= is_mul ? prod[31:0]  : quo;
      res_ok <= is_mul || (b != 32'd0);
    end else if (Busy) begin
      if (cnt == '0) begin
        Busy <= 1'b0;
        if (res_ok) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (md_op == MD_MTHI) begin
      hi <= a;
    end else if (md_op == MD_MTLO) begin
      lo <= a;
    end
  end

endmodule

// File: rtl/e_stage_unit.sv
// MIPS execute stage: operand forwarding, ALU, mult/div unit and the E/M
// pipeline registers.
module e_stage_unit
  import e_stage_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRE,
  input  logic [31:0] PC4E,
  input  logic [31:0] RSE,
  input  logic [31:0] RTE,
  input  logic [31:0] EXTE,
  input  logic [1:0]  Forward_RS_E_src,
  input  logic [1:0]  Forward_RT_E_src,
  input  logic [31:0] AO_M,
  input  logic [31:0] PC4_forw_M,
  input  logic [31:0] W_RF_WD_OUT,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] IRM,
  output logic [31:0] PC4M,
  output logic [31:0] AOM,
  output logic [31:0] RTM
);
  logic [31:0] a, b, ao, hi, lo;
  alu_op_e     alu_op;
  md_op_e      md_op;

  assign a      = fwd_sel(Forward_RS_E_src, RSE, AO_M, W_RF_WD_OUT, PC4_forw_M);
  assign b      = fwd_sel(Forward_RT_E_src, RTE, AO_M, W_RF_WD_OUT, PC4_forw_M);
  assign alu_op = decode_alu(IRE);
  assign md_op  = decode_md(IRE);

  always_comb begin
    ao = '0;
    case (alu_op)
      ALU_ADD:     ao = a + b;
      ALU_ADD_EXT: ao = a + EXTE;
      ALU_SUB:     ao = a - b;
      ALU_AND:     ao = a & b;
      ALU_OR:      ao = a | b;
      ALU_OR_EXT:  ao = a | EXTE;
      ALU_EXT:     ao = EXTE;
      ALU_SLT:     ao = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:    ao = {31'd0, a < b};
      ALU_SLL:     ao = b << IRE[10:6];
      ALU_HI:      ao = hi;
      ALU_LO:      ao = lo;
      default:     ao = '0;
    endcase
  end

  md_unit_E #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .Clk   (Clk),
    .Reset (Reset),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .Start (Start),
    .Busy  (Busy),
    .hi    (hi),
    .lo    (lo)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      IRM  <= '0;
      PC4M <= '0;
      AOM  <= '0;
      RTM  <= '0;
    end else begin
      IRM  <= IRE;
      PC4M <= PC4E;
      AOM  <= ao;
      RTM  <= b;
    end
  end

endmodule
